// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32/RV64 immediate generator with valid/ready handshake and a 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  logic             s, in_ill, acc, drn, skid_valid, skid_ill;
  logic [XLEN-1:0]  in_imm, skid_imm;
  logic [TAG_W-1:0] skid_tag;
  assign s = in_instr[31];
  always_comb
    in_imm = in_imm_src == 3'd0 ? {{(XLEN-12){s}}, in_instr[31:20]} :
             in_imm_src == 3'd1 ? {{(XLEN-12){s}}, in_instr[31:25], in_instr[11:7]} :
             in_imm_src == 3'd2 ? {{(XLEN-12){s}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
             in_imm_src == 3'd3 ? {{(XLEN-20){s}}, in_instr[31:12]} << 12 :
             in_imm_src == 3'd4 ? {{(XLEN-20){s}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
             in_imm_src == 3'd5 ? {{(XLEN-5){1'b0}}, in_instr[19:15]} : '0;
  assign in_ill   = in_imm_src[2] & in_imm_src[1];
  assign in_ready = !skid_valid;
  assign acc      = in_valid & in_ready;
  assign drn      = out_valid & out_ready;
  // SKID only fills while OUT is stalled, so it always holds the younger beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
      skid_valid  <= 1'b0;
      skid_imm    <= '0;
      skid_ill    <= 1'b0;
      skid_tag    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || drn) begin
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_illegal <= skid_ill;
        out_tag     <= skid_tag;
        skid_valid  <= 1'b0;
      end else begin
        out_valid <= acc;
        if (acc) begin
          out_imm     <= in_imm;
          out_illegal <= in_ill;
          out_tag     <= in_tag;
        end
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_imm   <= in_imm;
      skid_ill   <= in_ill;
      skid_tag   <= in_tag;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and random checks of imm_gen_pipe (XLEN 32 and 64) against a FIFO reference model
module tb_imm_gen_pipe;
  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_instr = 0, in_tag = 0;
  logic [2:0]  in_imm_src = 0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_tag;
  logic        r64, v64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  int total = 0, bad = 0;
  typedef struct {logic [63:0] imm; logic ill; logic [31:0] tag;} beat_t;
  beat_t q[$];

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_illegal(out_illegal), .out_tag(out_tag));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(v64),
    .out_ready(out_ready), .out_imm(imm64), .out_illegal(ill64), .out_tag(tag64));

  always #5 clk = ~clk;

  // immediate value as a signed number built from the instruction fields
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
    longint si = longint'($signed(ins));
    longint u  = longint'(ins);
    case (src)
      3'd0: return si >>> 20;
      3'd1: return ((si >>> 25) * 32) + ((u >> 7) & 31);
      3'd2: return ((si >>> 31) * 4096) + (((u >> 7) & 1) * 2048) + (((u >> 25) & 63) * 32) + (((u >> 8) & 15) * 2);
      3'd3: return (si >>> 12) * 4096;
      3'd4: return ((si >>> 31) * (1 << 20)) + (((u >> 12) & 255) * 4096) + (((u >> 20) & 1) * 2048) + (((u >> 21) & 1023) * 2);
      3'd5: return (u >> 15) & 31;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tg);
    in_valid = v; in_instr = ins; in_imm_src = src; in_tag = tg;
  endtask

  task automatic step();
    bit acc, drn;
    beat_t b;
    acc = in_valid && q.size() < 2 && !rst;
    drn = q.size() > 0 && out_ready;
    b = '{ref_imm(in_instr, in_imm_src), in_imm_src >= 3'd6, in_tag};
    @(posedge clk); #1;
    if (rst || flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("in_ready64", 64'(r64), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("out_valid64", 64'(v64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("imm32", 64'(out_imm), 64'(q[0].imm[31:0]));
      chk("imm64", imm64, q[0].imm);
      chk("illegal", 64'(out_illegal), 64'(q[0].ill));
      chk("tag", 64'(out_tag), 64'(q[0].tag));
      chk("tag64", 64'(tag64), 64'(q[0].tag));
    end
    if (rst) begin
      chk("rst_imm", 64'(out_imm), 0);
      chk("rst_imm64", imm64, 0);
      chk("rst_ill", 64'(out_illegal | ill64), 0);
      chk("rst_tag", 64'(out_tag | tag64), 0);
    end
  endtask

  initial begin
    step(); step();
    rst = 0;
    drive(1, 32'hFFF00093, 3'd0, 5); step();
    chk("t1_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("t1_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("t1_tag", 64'(out_tag), 5);
    drive(1, 32'hFE000EE3, 3'd2, 6); step();
    chk("t2_b", 64'(out_imm), 64'hFFFFFFFC);
    drive(1, 32'h00112623, 3'd1, 7); step();
    chk("t2_s", 64'(out_imm), 64'h0000000C);
    drive(1, 32'h12345037, 3'd3, 8); step();
    chk("t3_u", 64'(out_imm), 64'h12345000);
    drive(1, 32'h80000037, 3'd3, 9); step();
    chk("t3_u64", imm64, 64'hFFFFFFFF80000000);
    drive(1, 32'h000FD073, 3'd5, 10); step();
    chk("t3_z", 64'(out_imm), 64'h1F);
    drive(0, 0, 0, 0); step();
    out_ready = 0;
    for (int t = 1; t <= 3; t++) begin drive(1, $urandom, 3'($urandom_range(0, 5)), t); step(); end
    chk("t4_hold_ready", 64'(in_ready), 0);
    chk("t4_hold_tag", 64'(out_tag), 1);
    out_ready = 1; step();
    chk("t4_exit2", 64'(out_tag), 2);
    step();
    chk("t4_exit3", 64'(out_tag), 3);
    drive(0, 0, 0, 0); step();
    out_ready = 0;
    drive(1, $urandom, 3'd0, 10); step();
    drive(1, $urandom, 3'd1, 11); step();
    drive(1, $urandom, 3'd2, 12); flush = 1; step();
    chk("t5_valid", 64'(out_valid), 0);
    chk("t5_ready", 64'(in_ready), 1);
    flush = 0; drive(0, 0, 0, 0); out_ready = 1; step(); step();
    chk("t5_dropped", 64'(out_valid), 0);
    drive(1, 32'hFFFFFFFF, 3'd7, 13); step();
    chk("t6_ill", 64'(out_illegal), 1);
    chk("t6_imm", 64'(out_imm), 0);
    out_ready = 0;
    drive(1, $urandom, 3'd4, 14); step();
    drive(1, $urandom, 3'd0, 15); rst = 1; step();
    chk("t6_rst_valid", 64'(out_valid), 0);
    chk("t6_rst_ready", 64'(in_ready), 1);
    rst = 0; out_ready = 1;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), $urandom);
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 59) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
